// File: rtl/lsq_issue_select.sv
// lsq_issue_select: oldest-ready select, CDB wakeup and issue register for a collapsing shift queue.
// Define LSQ_ISSUE_WAKEUP_BYPASS_EN to make an entry selectable in the same cycle its last source is broadcast.
module lsq_issue_select #(
    parameter int N_ENTRIES     = 8,
    parameter int TAG_WIDTH     = 6,
    parameter int PAYLOAD_WIDTH = 67,
    localparam int ENTRY_WIDTH  = PAYLOAD_WIDTH + 2*TAG_WIDTH + 2,
    localparam int CTR_WIDTH    = $clog2(N_ENTRIES) + 1
) (
    input  logic                             clk,
    input  logic                             rst_aL,
    input  logic                             q_enq_fire,
    input  logic [N_ENTRIES*ENTRY_WIDTH-1:0] q_entry_douts,
    output logic                             q_deq_ready,
    output logic [N_ENTRIES-1:0]             q_deq_sel_onehot,
    input  logic                             q_deq_valid,
    input  logic [ENTRY_WIDTH-1:0]           q_deq_data,
    output logic [N_ENTRIES-1:0]             q_wr_en,
    output logic [N_ENTRIES*ENTRY_WIDTH-1:0] q_wr_data,
    input  logic                             cdb_valid,
    input  logic [TAG_WIDTH-1:0]             cdb_tag,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic [ENTRY_WIDTH-1:0]           iss_data
);
    localparam int R2 = 0;
    localparam int T2 = 1;
    localparam int R1 = TAG_WIDTH + 1;
    localparam int T1 = TAG_WIDTH + 2;

    logic [CTR_WIDTH-1:0]             r_count;
    logic                             r_iss_valid;
    logic [ENTRY_WIDTH-1:0]           r_iss_data;
    logic [N_ENTRIES*ENTRY_WIDTH-1:0] w_woken;
    logic [N_ENTRIES*ENTRY_WIDTH-1:0] w_woken_sh;
    logic [N_ENTRIES-1:0]             w_valid;
    logic [N_ENTRIES-1:0]             w_need;
    logic [N_ENTRIES-1:0]             w_rdy;
    logic [N_ENTRIES-1:0]             w_shift;
    logic [CTR_WIDTH-1:0]             w_sel_idx;
    logic                             w_any;
    logic                             w_deq_fire;
    logic [ENTRY_WIDTH-1:0]           w_cap;

    function automatic logic [ENTRY_WIDTH-1:0] f_wake(
        input logic [ENTRY_WIDTH-1:0] e,
        input logic                   v,
        input logic [TAG_WIDTH-1:0]   t
    );
        f_wake = e;
        if (v && e[T1 +: TAG_WIDTH] == t) f_wake[R1] = 1'b1;
        if (v && e[T2 +: TAG_WIDTH] == t) f_wake[R2] = 1'b1;
    endfunction

    always_comb begin
        w_woken          = '0;
        w_valid          = '0;
        w_need           = '0;
        w_rdy            = '0;
        w_shift          = '0;
        w_sel_idx        = '0;
        w_any            = 1'b0;
        q_deq_sel_onehot = '0;
        q_wr_data        = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_valid[i] = CTR_WIDTH'(i) < r_count;
            w_woken[i*ENTRY_WIDTH +: ENTRY_WIDTH] = f_wake(q_entry_douts[i*ENTRY_WIDTH +: ENTRY_WIDTH], cdb_valid, cdb_tag);
            w_need[i] = w_valid[i] && (w_woken[i*ENTRY_WIDTH +: ENTRY_WIDTH] != q_entry_douts[i*ENTRY_WIDTH +: ENTRY_WIDTH]);
`ifdef LSQ_ISSUE_WAKEUP_BYPASS_EN
            w_rdy[i] = w_valid[i] && w_woken[i*ENTRY_WIDTH + R1] && w_woken[i*ENTRY_WIDTH + R2];
`else
            w_rdy[i] = w_valid[i] && q_entry_douts[i*ENTRY_WIDTH + R1] && q_entry_douts[i*ENTRY_WIDTH + R2];
`endif
            if (w_rdy[i] && !w_any) begin
                q_deq_sel_onehot[i] = 1'b1;
                w_sel_idx           = CTR_WIDTH'(i);
                w_any               = 1'b1;
            end
        end
        q_deq_ready = w_any && (!r_iss_valid || iss_ready);
        w_deq_fire  = q_deq_ready && q_deq_valid;
        // slots at or above the leaving entry take the update of the entry that shifts into them
        w_woken_sh  = w_woken >> ENTRY_WIDTH;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_shift[i] = w_deq_fire && CTR_WIDTH'(i) >= w_sel_idx;
            q_wr_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = w_shift[i] ? w_woken_sh[i*ENTRY_WIDTH +: ENTRY_WIDTH]
                                                                 : w_woken[i*ENTRY_WIDTH +: ENTRY_WIDTH];
        end
        q_wr_en = (w_shift & (w_need >> 1)) | (~w_shift & w_need);
`ifdef LSQ_ISSUE_WAKEUP_BYPASS_EN
        w_cap = f_wake(q_deq_data, cdb_valid, cdb_tag);
`else
        w_cap = q_deq_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            r_iss_data  <= '0;
        end else begin
            assert (!(q_enq_fire && !w_deq_fire && r_count == CTR_WIDTH'(N_ENTRIES)));
            assert (!(w_deq_fire && !q_enq_fire && r_count == '0));
            r_count <= r_count + CTR_WIDTH'(q_enq_fire) - CTR_WIDTH'(w_deq_fire);
            if (w_deq_fire) begin
                r_iss_valid <= 1'b1;
                r_iss_data  <= w_cap;
            end else if (iss_ready) begin
                r_iss_valid <= 1'b0;
            end
        end
    end

    assign iss_valid = r_iss_valid;
    assign iss_data  = r_iss_data;
endmodule

// File: doc/lsq_issue_select.md
Name: lsq_issue_select

Overview:
- Issue/select stage directly downstream of the collapsing shift queue.
- Tracks queue occupancy and snoops the CDB. When a source tag is broadcast, writes the ready bit back into the matching entries through the queue's per-entry write port.
- Each cycle it picks the oldest entry with both sources ready, i.e. the lowest index, since the queue collapses toward index 0. It drives the queue's one-hot dequeue select and captures the dequeued entry in an output pipeline register facing the execute/AGU stage.

Parameters:
- N_ENTRIES, 8, queue depth; must match the attached shift queue.
- TAG_WIDTH, 6, physical register tag width.
- PAYLOAD_WIDTH, 67, opaque payload bits carried with the entry.
- ENTRY_WIDTH (localparam), PAYLOAD_WIDTH + 2*TAG_WIDTH + 2. Layout from MSB down: payload, src1_tag, src1_rdy, src2_tag, src2_rdy (bit 0).
- CTR_WIDTH (localparam), $clog2(N_ENTRIES)+1.

Ports:
- clk  in  1  clock
- rst_aL  in  1  asynchronous active-low reset
- q_enq_fire  in  1  queue enq_ready && enq_valid this cycle
- q_entry_douts  in  N_ENTRIES*ENTRY_WIDTH  current queue contents
- q_deq_ready  out  1  dequeue request to queue
- q_deq_sel_onehot  out  N_ENTRIES  selected entry, one-hot or all 0
- q_deq_valid  in  1  queue confirms the dequeue is valid
- q_deq_data  in  ENTRY_WIDTH  dequeued entry
- q_wr_en  out  N_ENTRIES  per-entry write enables (wakeup updates)
- q_wr_data  out  N_ENTRIES*ENTRY_WIDTH  per-entry write data
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_WIDTH  broadcast destination tag
- iss_valid  out  1  output register holds an entry
- iss_ready  in  1  downstream accepts
- iss_data  out  ENTRY_WIDTH  issued entry

Behaviour:
- Reset (async, rst_aL=0):
  - occupancy count = 0, iss_valid = 0, iss_data = 0.
  - q_deq_ready = 0, q_deq_sel_onehot = 0, q_wr_en = 0.
  - A reset mid-operation discards the output register content immediately.
- Valid mask: entry i is valid iff i < count.
- Count update:
  - count_next = count + q_enq_fire - deq_fire, where deq_fire = q_deq_ready && q_deq_valid.
  - count never exceeds N_ENTRIES or drops below 0 (assertion).
  - Simultaneous enq and deq leaves count unchanged.
- Ready: entry i is ready iff valid && src1_rdy && src2_rdy.
- Select: q_deq_sel_onehot = lowest-index ready entry; all 0 if none is ready.
- Dequeue handshake:
  - q_deq_ready = (any entry ready) && (!iss_valid || iss_ready).
  - On deq_fire, iss_data <= q_deq_data and iss_valid <= 1 next cycle, so issue latency is 1 cycle from selection.
  - If iss_ready && !deq_fire, then iss_valid <= 0.
  - If iss_valid && !iss_ready, iss_data is held stable and no dequeue occurs.
- Wakeup:
  - When cdb_valid, every valid entry with (src1_tag == cdb_tag && !src1_rdy) or the src2 equivalent gets its rdy bit(s) set. The write is sent via q_wr_en/q_wr_data; all other fields are unchanged.
  - If both sources match, both bits are set in one write.
  - Invalid entries are never written.
- Wakeup during dequeue: the write is indexed to the post-shift position.
  - Entry i above the selected index s is written at i-1.
  - Entry s itself is not written, because it is leaving.
  - Entries below s keep index i.
- Wakeup on the enqueue cycle: the newly enqueued entry is not snooped; the enqueue side is responsible for same-cycle bypass.
- An empty queue (count=0) gives no select and no writes. With a full queue, select and wakeup behave normally.

Optional Feature:
- Macro: LSQ_ISSUE_WAKEUP_BYPASS_EN.
- Defined:
  - A valid entry whose only missing source(s) match the current cdb_tag counts as ready for selection in the same cycle.
  - When such an entry is dequeued, the captured iss_data has the matching rdy bit(s) forced to 1. Issue occurs 1 cycle after the broadcast.
- Undefined:
  - The entry becomes selectable only the cycle after its wakeup write lands, so issue occurs 2 cycles after the broadcast.

Test Plan (N_ENTRIES=4, TAG_WIDTH=6):
- Reset while iss_valid=1 -> iss_valid=0, count=0 and q_deq_ready=0 immediately, with no clock edge required.
- 3 enqueues with all rdy=1 and iss_ready=1 -> sel=0001 each cycle; iss_data equals entries 0,1,2 in order on consecutive cycles; count returns to 0.
- Entries 0,1 waiting on tag 5 and entry 2 ready -> sel=0100. cdb_tag=5 in the same cycle -> q_wr_en=0011 (no shift below index 2); entry 0 issues next.
- Entry 0 ready, entry 2 waiting on tag 9, cdb_tag=9 while deq_fire of entry 0 -> q_wr_en=0010 with src rdy set; entry 1 (the former entry 2) issues later.
- iss_ready=0 with iss_valid=1 and a ready entry -> q_deq_ready=0, iss_data stable for 3 cycles; iss_ready=1 -> dequeue fires the same cycle, back-to-back.
- Bypass: entry 0 waiting on tag 3, cdb_tag=3 at cycle t -> with the macro defined, iss_valid=1 at t+1 and src rdy=1 in iss_data; without the macro, iss_valid=1 at t+2.
